// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - DEFAULT_WIDTH : default operand width
//   - state_e       : controller states (LOAD, CALC, DONE)
//   - cnt_width()   : width of the step counter for a given operand width
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The step counter must hold 0..width-1, with a one-bit floor for width 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_if.sv
// mult_if
// Operand and product bundle of the multiplier.
//   da : multiplicand, WIDTH bits, unsigned
//   db : multiplier,   WIDTH bits, unsigned
//   p  : product,      2*WIDTH bits, held between results
// master drives the operands and reads the product; slave is the multiplier.
interface mult_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   da;
    logic [WIDTH-1:0]   db;
    logic [2*WIDTH-1:0] p;

    modport master (output da, output db, input p);
    modport slave  (input da, input db, output p);
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl
// Free-running controller: LOAD for one cycle, CALC for WIDTH cycles, DONE for
// one cycle, then back to LOAD.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   load  : strobe, sample operands and clear the accumulator
//   step  : strobe, perform one add/shift step
//   done  : strobe, publish the product
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    output logic load,
    output logic step,
    output logic done
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        case (state_q)
            LOAD: begin
                load    = 1'b1;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                step  = 1'b1;
                // May wrap on the last step; LOAD clears it again.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule

// File: rtl/mult_datapath.sv
// mult_datapath
// Shift-and-add datapath: M (multiplicand), Q (multiplier, fills with the
// low product bits), A (accumulator with carry) and the held product p.
//   clk, reset : clock and asynchronous active-low reset
//   load       : M<-da, Q<-db, A<-0
//   step       : {A,Q} <- ({A + (Q[0] ? M : 0), Q}) >> 1
//   done       : p <- {A[WIDTH-1:0], Q}
//   da, db     : operands
//   p          : product register
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               done,
    input  logic [WIDTH-1:0]   da,
    input  logic [WIDTH-1:0]   db,
    output logic [2*WIDTH-1:0] p
);

    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0;
            q_q <= '0;
            a_q <= '0;
            p_q <= '0;
        end else begin
            m_q <= m_d;
            q_q <= q_d;
            a_q <= a_d;
            p_q <= p_d;
        end
    end

    always_comb begin
        m_d    = m_q;
        q_d    = q_q;
        a_d    = a_q;
        p_d    = p_q;
        // Sum is one bit wider than M so the carry survives into the shift.
        addend = q_q[0] ? {1'b0, m_q} : '0;
        sum    = a_q + addend;
        if (load) begin
            m_d = da;
            q_d = db;
            a_d = '0;
        end else if (step) begin
            // Right shift of {sum, Q}: sum's LSB moves into Q's MSB, 0 enters A.
            a_d = {1'b0, sum[WIDTH:1]};
            q_d = {sum[0], q_q[WIDTH-1:1]};
        end else if (done) begin
            p_d = {a_q[WIDTH-1:0], q_q};
        end
    end

    assign p = p_q;

endmodule

// File: rtl/seq_mult_top.sv
// seq_mult_top
// Free-running sequential unsigned multiplier. Operands are sampled once per
// WIDTH+2 cycle period and the product is published on a held register.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mult_if slave (da, db in; p out)
module seq_mult_top
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic   clk,
    input  logic   reset,
    mult_if.slave  bus
);

    logic load;
    logic step;
    logic done;

    mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .done  (done)
    );

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .done  (done),
        .da    (bus.da),
        .db    (bus.db),
        .p     (bus.p)
    );

endmodule

// File: tb/tb_seq_mult_top.sv
// tb_seq_mult_top
// Scoreboard bench: each issued operand pair pushes its product into a queue;
// a monitor counts edges since reset release and, on every result edge, pops
// and compares, checking that p holds (or reads 0 while in reset) otherwise.
module tb_seq_mult_top;

    localparam int W      = 4;
    localparam int PERIOD = W + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mult_if #(.WIDTH(W)) bus_if ();

    seq_mult_top #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int               edge_cnt;
    int               total = 0;
    int               bad   = 0;
    logic [2*W-1:0]   sb[$];
    logic [2*W-1:0]   held  = '0;
    logic [2*W-1:0]   exp_v;
    bit               mon_en = 1'b1;

    // Rising edges since the last reset release; result edges are multiples
    // of the period.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [2*W-1:0] got,
                               input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
        int prod;
        prod = int'(a) * int'(b);
        return (2*W)'(prod);
    endfunction

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                held = '0;
                checkOutput("p_in_reset", bus_if.p, '0);
            end else if (edge_cnt > 0 && (edge_cnt % PERIOD) == 0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_empty: got result edge %0d expected a queued product", edge_cnt);
                end else begin
                    exp_v = sb.pop_front();
                    checkOutput("p_done", bus_if.p, exp_v);
                    held = exp_v;
                end
            end else begin
                checkOutput("p_hold", bus_if.p, held);
            end
        end
    end

    // Present a/b for the next LOAD edge; optionally scramble inputs mid-CALC.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((edge_cnt % PERIOD) != 0 && guard < 4 * PERIOD);
        if ((edge_cnt % PERIOD) != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL load_slot_timeout: got edge %0d expected a load slot", edge_cnt);
        end
        bus_if.da = a;
        bus_if.db = b;
        sb.push_back(refProduct(a, b));
        @(posedge clk);
        if (scramble) begin
            @(negedge clk);
            bus_if.da = W'($urandom_range(0, (1 << W) - 1));
            bus_if.db = W'($urandom_range(0, (1 << W) - 1));
        end
    endtask

    // While reset is held, set the first operands and release so that the
    // next rising edge is edge 1 (LOAD).
    task automatic startAfterReset(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.delete();
        bus_if.da = a;
        bus_if.db = b;
        sb.push_back(refProduct(a, b));
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
    endtask

    // Assert reset just after edge 3 of a period and check p clears at once.
    task automatic resetMidCalc();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((edge_cnt % PERIOD) != 2 && guard < 4 * PERIOD);
        @(posedge clk);
        #2 reset = 1'b0;
        sb.delete();
        #1 checkOutput("p_async_clear", bus_if.p, '0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int guard;
        bus_if.da = '0;
        bus_if.db = '0;
        #1 reset = 1'b0;
        #1 checkOutput("p_reset", bus_if.p, '0);

        startAfterReset(4'd11, 4'd13);
        applyStimulus(4'd11, 4'd13, 1'b0);
        applyStimulus(4'd11, 4'd13, 1'b0);
        applyStimulus(4'd15, 4'd15, 1'b0);
        applyStimulus(4'd0,  4'd9,  1'b0);
        applyStimulus(4'd9,  4'd0,  1'b0);
        applyStimulus(4'd1,  4'd9,  1'b1);
        applyStimulus(4'd7,  4'd3,  1'b0);
        applyStimulus(4'd11, 4'd13, 1'b0);

        resetMidCalc();
        startAfterReset(4'd11, 4'd13);

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                applyStimulus(W'(a), W'(b), 1'b0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            applyStimulus(ra, rb, 1'b1);
        end

        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (sb.size() != 0 && guard < 4 * PERIOD);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
